uart_tx_arbiter: RTL and testbench

Shares the single `uart_tx_path` transmitter between `NUM_REQ` byte sources (timer report, RX echo, status) using round-robin arbitration. Each accepted byte produces one `uart_tx_enable` pulse, and the block then holds off further grants for one full frame time. It sits between the producers and `u_uart_tx_path` in `top`, replacing the direct pps-to-enable logic.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rr_pick.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit arbiter.
package uart_pkg;

  localparam int CLK_HZ    = 50_000_000;
  localparam int UART_BAUD = 115200;

  // One frame is 10 bit times (start + 8 data + stop), rounded up to whole clocks.
  localparam int UART_BYTE_CYCLES = (10 * CLK_HZ + UART_BAUD - 1) / UART_BAUD;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches upward from the slot after the
// last grant, wrapping modulo NUM_REQ, and returns a one-hot grant plus index.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [2:0]         idx_o,
  output logic               any_o
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

  logic [7:0] req_pad_s;
  logic [2:0] cand_s;
  logic [2:0] idx_s;
  logic       found_s;
  logic       hit_s;

  // Walk the ring once starting after last_i; the first set request wins.
  always_comb begin
    req_pad_s                = 8'h00;
    req_pad_s[NUM_REQ-1:0]   = req_i;
    cand_s                   = last_i;
    idx_s                    = 3'd0;
    found_s                  = 1'b0;
    hit_s                    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s  = (cand_s == LAST_IDX) ? 3'd0 : cand_s + 3'd1;
      hit_s   = !found_s && req_pad_s[cand_s];
      idx_s   = hit_s ? cand_s : idx_s;
      found_s = found_s | hit_s;
    end
    gnt_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      gnt_o[j] = found_s && (idx_s == 3'(j));
    end
    idx_o = idx_s;
    any_o = found_s;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// sources. Each grant launches one frame and then blocks further grants for
// BYTE_CYCLES clocks so the transmitter is never restarted mid-frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int BYTE_CYCLES = UART_BYTE_CYCLES
) (
  input  logic                   clk_50m,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_enable,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [15:0]            byte_count
);

  localparam int               CNT_W     = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BYTE_CYCLES - 1);
  localparam logic [2:0]       GRANT_RST = 3'(NUM_REQ - 1);

  uart_arb_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_enable_q, tx_enable_d;
  logic             busy_q, busy_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic [15:0]      byte_count_q, byte_count_d;

  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [2:0]         pick_idx_s;
  logic               pick_any_s;
  logic [63:0]        data_pad_s;
  logic [7:0]         pick_byte_s;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (grant_id_q),
    .gnt_o  (pick_gnt_s),
    .idx_o  (pick_idx_s),
    .any_o  (pick_any_s)
  );

  // Select the winning requester's byte out of the packed data bus.
  always_comb begin
    data_pad_s                  = 64'h0;
    data_pad_s[NUM_REQ*8-1:0]   = req_data;
    pick_byte_s                 = data_pad_s[{pick_idx_s, 3'b000} +: 8];
  end

  // Next-state logic: grant in IDLE, then count out one frame slot in SEND.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    tx_enable_d  = 1'b0;
    busy_d       = busy_q;
    grant_id_d   = grant_id_q;
    byte_count_d = byte_count_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d      = SEND;
          cnt_d        = CNT_LOAD;
          tx_data_d    = pick_byte_s;
          tx_enable_d  = 1'b1;
          busy_d       = 1'b1;
          grant_id_d   = pick_idx_s;
          byte_count_d = byte_count_q + 16'd1;
        end else begin
          busy_d = 1'b0;
        end
      end
      SEND: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset truncates any frame in flight.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tx_data_q    <= 8'h00;
      tx_enable_q  <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= GRANT_RST;
      byte_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_enable_q  <= tx_enable_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      byte_count_q <= byte_count_d;
    end
  end

  // Accept strobe is combinational so the requester sees it in the grant cycle.
  always_comb begin
    if (state_q == IDLE) begin
      req_ready = pick_gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  assign uart_tx_data   = tx_data_q;
  assign uart_tx_enable = tx_enable_q;
  assign busy           = busy_q;
  assign grant_id       = grant_id_q;
  assign byte_count     = byte_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with NUM_REQ=3, BYTE_CYCLES=8.
// Expected bytes/ids are queued as stimulus is applied and popped on each
// uart_tx_enable pulse.
module tb_uart_tx_arbiter;

  localparam int NREQ = 3;
  localparam int BC   = 8;

  logic              clk_50m;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_enable;
  logic              busy;
  logic [2:0]        grant_id;
  logic [15:0]       byte_count;

  typedef struct {
    logic [7:0] data;
    logic [2:0] id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (NREQ),
    .BYTE_CYCLES (BC)
  ) dut (
    .clk_50m        (clk_50m),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_enable (uart_tx_enable),
    .busy           (busy),
    .grant_id       (grant_id),
    .byte_count     (byte_count)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  // Scoreboard monitor: every enable pulse must match the oldest expectation.
  always @(negedge clk_50m) begin
    if (reset_n && uart_tx_enable) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data %h id %0d, required no pulse", uart_tx_data, grant_id);
      end else begin
        mon_e = sb_q.pop_front();
        if (uart_tx_data !== mon_e.data || grant_id !== mon_e.id) begin
          errors++;
          $display("FAIL sb_byte: got data %h id %0d, required data %h id %0d",
                   uart_tx_data, grant_id, mon_e.data, mon_e.id);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic [2:0] id);
    exp_t e;
    e.data = d;
    e.id   = id;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk_50m);
    reset_n = 1'b1;
    @(negedge clk_50m);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk_50m);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy %b, required 0 within 40 cycles", name, busy);
    end
    @(negedge clk_50m);
  endtask

  task automatic test_reset();
    int pulses;
    do_reset();
    checks++;
    if (req_ready !== 3'b000 || uart_tx_data !== 8'h00 || uart_tx_enable !== 1'b0 ||
        busy !== 1'b0 || grant_id !== 3'd2 || byte_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values: got rdy %b data %h en %b busy %b gid %0d cnt %h, required 000 00 0 0 2 0000",
               req_ready, uart_tx_data, uart_tx_enable, busy, grant_id, byte_count);
    end
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50m);
      if (uart_tx_enable) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_idle_enable: got %0d pulses, required 0", pulses);
    end
  endtask

  task automatic test_single();
    int n;
    req_valid = 3'b010;
    req_data  = 24'h00A500;
    push_exp(8'hA5, 3'd1);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL single_ready: got %b, required 010", req_ready);
    end
    @(posedge clk_50m);
    #1 req_valid = '0;
    @(negedge clk_50m);
    checks++;
    if (uart_tx_enable !== 1'b1 || uart_tx_data !== 8'hA5 || grant_id !== 3'd1 ||
        byte_count !== 16'd1 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL single_out: got en %b data %h gid %0d cnt %0d rdy %b, required 1 a5 1 1 000",
               uart_tx_enable, uart_tx_data, grant_id, byte_count, req_ready);
    end
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk_50m);
    end
    checks++;
    if (n !== BC) begin
      errors++;
      $display("FAIL single_busy_len: got %0d cycles, required %0d", n, BC);
    end
    checks++;
    if (uart_tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_data_hold: got %h, required a5", uart_tx_data);
    end
    @(negedge clk_50m);
  endtask

  task automatic test_round_robin();
    int times[4];
    int n;
    do_reset();
    req_data  = 24'h121110;
    req_valid = 3'b111;
    push_exp(8'h10, 3'd0);
    push_exp(8'h11, 3'd1);
    push_exp(8'h12, 3'd2);
    push_exp(8'h10, 3'd0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50m);
      if (uart_tx_enable) begin
        times[n] = i;
        n++;
        if (n == 4) begin
          req_valid = '0;
          break;
        end
      end
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL rr_count: got %0d pulses, required 4", n);
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (times[k] - times[k-1] !== BC + 1) begin
          errors++;
          $display("FAIL rr_period: got %0d cycles, required %0d", times[k] - times[k-1], BC + 1);
        end
      end
    end
    wait_idle("rr");
  endtask

  task automatic test_mid_send();
    req_valid = 3'b001;
    req_data  = 24'h000030;
    push_exp(8'h30, 3'd0);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL mid_ready0: got %b, required 001", req_ready);
    end
    @(posedge clk_50m);
    #1 req_valid = '0;
    @(negedge clk_50m);
    repeat (3) @(negedge clk_50m);
    req_valid = 3'b100;
    req_data  = 24'h420000;
    push_exp(8'h42, 3'd2);
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL mid_ready_send: got %b, required 000", req_ready);
    end
    repeat (5) @(negedge clk_50m);
    checks++;
    if (busy !== 1'b0 || req_ready !== 3'b100) begin
      errors++;
      $display("FAIL mid_idle_grant: got busy %b rdy %b, required 0 100", busy, req_ready);
    end
    @(posedge clk_50m);
    #1 req_valid = '0;
    @(negedge clk_50m);
    checks++;
    if (uart_tx_enable !== 1'b1 || grant_id !== 3'd2) begin
      errors++;
      $display("FAIL mid_enable: got en %b gid %0d, required 1 2", uart_tx_enable, grant_id);
    end
    wait_idle("mid");
  endtask

  task automatic test_reset_mid_send();
    req_valid = 3'b001;
    req_data  = 24'h000055;
    push_exp(8'h55, 3'd0);
    @(posedge clk_50m);
    #1 req_valid = '0;
    @(negedge clk_50m);
    repeat (3) @(negedge clk_50m);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || uart_tx_enable !== 1'b0 || byte_count !== 16'h0000 || grant_id !== 3'd2) begin
      errors++;
      $display("FAIL rst_mid_clear: got busy %b en %b cnt %h gid %0d, required 0 0 0000 2",
               busy, uart_tx_enable, byte_count, grant_id);
    end
    @(negedge clk_50m);
    reset_n = 1'b1;
    @(negedge clk_50m);
    req_valid = 3'b011;
    req_data  = 24'h006160;
    push_exp(8'h60, 3'd0);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL rst_mid_first: got %b, required 001", req_ready);
    end
    @(posedge clk_50m);
    #1 req_valid = '0;
    @(negedge clk_50m);
    wait_idle("rst_mid");
  endtask

  task automatic test_wrap();
    force dut.byte_count_q = 16'hFFFF;
    @(negedge clk_50m);
    release dut.byte_count_q;
    @(negedge clk_50m);
    req_valid = 3'b010;
    req_data  = 24'h007700;
    push_exp(8'h77, 3'd1);
    @(posedge clk_50m);
    #1 req_valid = '0;
    @(negedge clk_50m);
    checks++;
    if (byte_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_count: got %h, required 0000", byte_count);
    end
    wait_idle("wrap");
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_mid_send();
    test_reset_mid_send();
    test_wrap();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
